// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock, with the full round-key table expanded
// one word per clock into registers after each key load.
module aes_decrypt_iter #(
  parameter int KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [255:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  // state  | meaning
  // IDLE   | waiting for a key load or, once key_ready, a ciphertext block
  // EXPAND | writing one round-key word per cycle
  // ROUND  | applying one inverse round per cycle, cnt counts down to 0
  // DONE   | plaintext held on out_data until out_ready
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6     = 6'(NK);
  localparam logic [5:0] W_LAST  = 6'(NW - 1);
  localparam logic [2:0] PH_LAST = 3'(NK - 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Byte b = row + 4*col sits at bits [127-8b -: 8].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(r + 4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r + 1) % 4], 8'h0b) ^
                                    gmul(a[(r + 2) % 4], 8'h0d) ^ gmul(a[(r + 3) % 4], 8'h09);
    end
    return o;
  endfunction

  state_t       state;
  logic [31:0]  w [NW];
  logic [5:0]   widx;
  logic [2:0]   ph;
  logic [7:0]   rcon;
  logic [3:0]   cnt;
  logic [127:0] st;

  logic [31:0]  prev, sw_in, sw_out, temp;
  logic [3:0]   rk_idx;
  logic [5:0]   rb;
  logic [127:0] rk, sb, mc;

  // Single SubWord unit: RotWord is applied in front of it only on the rcon step.
  always_comb begin
    prev  = w[widx - 6'd1];
    sw_in = (ph == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sw_out = sub_word(sw_in);
    temp  = prev;
    if (ph == 3'd0)
      temp = sw_out ^ {rcon, 24'h0};
    else if (NK == 8 && ph == 3'd4)
      temp = sw_out;
  end

  assign rk_idx = (state == S_ROUND) ? cnt : 4'(NR);
  assign rb     = {rk_idx, 2'b00};
  assign rk     = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};
  assign sb     = inv_shift_sub(st) ^ rk;
  assign mc     = inv_mix(sb);

  assign in_ready = (state == S_IDLE) && key_ready && !key_load;
  assign busy     = (state == S_EXPAND) || (state == S_ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      rcon      <= 8'h01;
      widx      <= '0;
      ph        <= '0;
      st        <= '0;
      for (int j = 0; j < NW; j++) w[j] <= '0;
    end else if (key_load) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[255 - 32*j -: 32];
      widx      <= NK6;
      ph        <= '0;
      rcon      <= 8'h01;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      state     <= S_EXPAND;
    end else begin
      case (state)
        S_EXPAND: begin
          w[widx] <= w[widx - NK6] ^ temp;
          widx    <= widx + 6'd1;
          ph      <= (ph == PH_LAST) ? 3'd0 : ph + 3'd1;
          if (ph == 3'd0) rcon <= xt(rcon);
          if (widx == W_LAST) begin
            key_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (in_valid && key_ready) begin
            st    <= in_data ^ rk;
            cnt   <= 4'(NR - 1);
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (cnt != 4'd0) begin
            st  <= mc;
            cnt <= cnt - 4'd1;
          end else begin
            out_data  <= sb;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 SHALL have parameter KEY_BITS, default 256: AES key size; legal values 128, 192, 256; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port key_load, input, 1: one-cycle strobe that captures key_in and starts key expansion.
REQ-005 SHALL have port key_in, input, 256: cipher key, left-aligned; bits [255:256-KEY_BITS] are used and the rest are ignored.
REQ-006 SHALL have port key_ready, output, 1: round-key table is complete and valid.
REQ-007 SHALL have port in_valid, input, 1: in_data holds a ciphertext block.
REQ-008 SHALL have port in_ready, output, 1: the core can accept a block this cycle.
REQ-009 SHALL have port in_data, input, 128: ciphertext, byte 0 in bits [127:120].
REQ-010 SHALL have port out_valid, output, 1: out_data holds a plaintext block.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts out_data.
REQ-012 SHALL have port out_data, output, 128: plaintext, same byte order as in_data.
REQ-013 SHALL have port busy, output, 1: the core is in EXPAND or ROUND.

Function
REQ-014 SHALL derive Nk = KEY_BITS/32, Nr = Nk+6 and W = 4(Nr+1) (44/52/60 words).
REQ-015 SHALL implement states IDLE, EXPAND, ROUND, DONE.
REQ-016 SHALL load key_load with w[0..Nk-1] from key_in, clear key_ready, and enter EXPAND; i = Nk and rcon = 8'h01.
REQ-017 SHALL generate one 32-bit word per cycle in EXPAND, per FIPS-197: w[i] = w[i-Nk] ^ temp.
REQ-018 SHALL compute temp as SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod Nk = 0, after which rcon = xtime(rcon).
REQ-019 SHALL compute temp as SubWord(w[i-1]) when Nk = 8 and i mod 8 = 4, and as w[i-1] otherwise.
REQ-020 SHALL store all W words (max 60x32) in a register table.
REQ-021 SHALL leave EXPAND when word W-1 is written: key_ready = 1, state = IDLE; key_ready SHALL rise exactly W-Nk cycles after the key_load sampling edge (40/46/52).
REQ-022 SHALL drive in_ready = (state == IDLE) & key_ready & ~key_load, combinationally.
REQ-023 SHALL, on in_valid & in_ready: state_reg = in_data ^ rk[Nr], cnt = Nr-1, enter ROUND; rk[r] = {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
REQ-024 SHALL apply one round per cycle in ROUND while cnt > 0: InvShiftRows, InvSubBytes, AddRoundKey rk[cnt], InvMixColumns; then cnt decrements.
REQ-025 SHALL apply the last round when cnt = 0: InvShiftRows, InvSubBytes, AddRoundKey rk[0], no InvMixColumns; out_data is loaded, out_valid = 1, state = DONE.
REQ-026 SHALL produce latency from the accept edge to out_valid high of exactly Nr cycles (10/12/14).
REQ-027 SHALL hold out_data and out_valid stable in DONE until out_ready is sampled high; then out_valid = 0 and state = IDLE; there SHALL be no accept in that same cycle.
REQ-028 SHALL give key_load priority in any state: an in-flight or pending block is discarded (out_valid = 0 next cycle) and expansion restarts.
REQ-029 SHALL treat a key_load asserted in the same cycle as in_valid by not accepting in_valid (in_ready = 0).
REQ-030 SHALL ignore in_valid while key_ready = 0; no block is lost because in_ready = 0.
REQ-031 SHALL keep out_data unchanged outside the load in REQ-025.
REQ-032 SHALL use round datapath logic consisting of one shared InvSubBytes/InvMixColumns stage and one SubWord unit, with no unrolled rounds.

Reset
REQ-033 SHALL, while rst_n = 0 (asynchronously): state = IDLE, key_ready = 0, out_valid = 0, out_data = 0, busy = 0, cnt = 0, rcon = 8'h01, and the key table cleared to 0.
REQ-034 SHALL make in_ready 0 after reset until a key has been expanded.
REQ-035 SHALL, after reset deasserts mid-operation, require a new key_load before accepting data.

Verification
REQ-036 KEY_BITS=256: key 000102...1f, ct 8ea2b7ca516745bfeafc49904b496089 -> pt 00112233445566778899aabbccddeeff; key_ready exactly 52 cycles after key_load; out_valid exactly 14 cycles after accept.
REQ-037 KEY_BITS=128: key 000102...0f (in [255:128]), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> the same pt; key_ready at 40 cycles; latency 10 cycles.
REQ-038 KEY_BITS=192: key 000102...17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> the same pt; key_ready at 46 cycles; latency 12 cycles.
REQ-039 Backpressure: hold out_ready = 0 for 20 cycles -> out_data is stable, in_ready = 0, busy = 0; after one out_ready pulse -> out_valid = 0 and in_ready = 1 on the next cycle.
REQ-040 key_load at round 5 of a block -> no out_valid for that block, a new expansion runs, and the next block decrypts under the new key; key_load together with in_valid -> the block is not accepted.
REQ-041 rst_n pulsed low mid-ROUND -> all outputs are 0 immediately; in_valid after release is ignored until key_load and expansion complete.
